// File: rtl/arb_rr_oht.sv
// arb_rr_oht
//   Registered round-robin arbiter. The request vector is masked with the bits
//   above the last-served pointer and resolved to a one-hot grant using the
//   rightmost-one (LSB-first) rule. If the masked vector is empty, the unmasked
//   vector is used instead, which gives the wrap-around. The grant is held under
//   a valid/ready handshake.
//
//   Optional feature (macro ARB_RR_LOCK_EN): adds input lck. When a transfer
//   happens with lck=1 and the granted requester is still requesting, that
//   requester is re-granted and the pointer is left alone. This supports
//   multi-beat bursts.
//
// Ports
//   clk      in   clock; all state updates on the rising edge
//   rst_n    in   asynchronous active-low reset
//   req      in   [WIDTH]      request vector, bit i = requester i
//   gnt      out  [WIDTH]      registered one-hot grant, zero when idle
//   gnt_idx  out  [WIDTH_LOG]  binary index of gnt, zero when idle
//   gnt_vld  out  grant valid
//   gnt_rdy  in   consumer accepts grant (transfer = gnt_vld & gnt_rdy)
//   lck      in   hold ownership across a transfer (ARB_RR_LOCK_EN only)
//
// State is implied by gnt_vld, so there is no separate state register.
//   state | meaning
//   IDLE  | gnt_vld=0, no grant outstanding; gnt_rdy ignored
//   GRANT | gnt_vld=1, gnt/gnt_idx held until gnt_rdy

module arb_rr_oht #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         req,
  output logic [WIDTH-1:0]         gnt,
  output logic [$clog2(WIDTH)-1:0] gnt_idx,
  output logic                     gnt_vld,
  input  logic                     gnt_rdy
`ifdef ARB_RR_LOCK_EN
  ,
  input  logic                     lck
`endif
);

  localparam int WIDTH_LOG = $clog2(WIDTH);

  logic [WIDTH-1:0]     gnt_q,     gnt_d;
  logic [WIDTH_LOG-1:0] gnt_idx_q, gnt_idx_d;
  logic                 gnt_vld_q, gnt_vld_d;
  logic [WIDTH-1:0]     lst_q,     lst_d;

  logic                 xfer;
  logic                 ld;
  logic                 lock_hold;
  logic [WIDTH-1:0]     ptr;
  logic [WIDTH-1:0]     msk;
  logic [WIDTH-1:0]     req_msk;
  logic [WIDTH-1:0]     sel;

  function automatic logic [WIDTH-1:0] rightmost_one(input logic [WIDTH-1:0] v);
    return v & (~v + WIDTH'(1));
  endfunction

  function automatic logic [WIDTH_LOG-1:0] encode(input logic [WIDTH-1:0] v);
    logic [WIDTH_LOG-1:0] idx;
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) idx = idx | WIDTH_LOG'(i);
    end
    return idx;
  endfunction

  always_comb begin
    xfer = gnt_vld_q & gnt_rdy;
    ld   = ~gnt_vld_q | gnt_rdy;

`ifdef ARB_RR_LOCK_EN
    lock_hold = xfer & lck & (|(req & gnt_q));
`else
    lock_hold = 1'b0;
`endif

    ptr = xfer ? gnt_q : lst_q;

    // msk[i] is set for every bit strictly above the pointer's set bit.
    msk = '0;
    for (int i = 1; i < WIDTH; i++) begin
      msk[i] = msk[i-1] | ptr[i-1];
    end

    req_msk = req & msk;
    if (lock_hold) begin
      sel = gnt_q;
    end else if (|req_msk) begin
      sel = rightmost_one(req_msk);
    end else begin
      sel = rightmost_one(req);
    end

    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    gnt_vld_d = gnt_vld_q;
    lst_d     = lst_q;

    if (ld) begin
      gnt_d     = sel;
      gnt_idx_d = encode(sel);
      gnt_vld_d = |req;
    end

    if (xfer && !lock_hold) begin
      lst_d = gnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      gnt_vld_q <= 1'b0;
      lst_q     <= {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_vld_q <= gnt_vld_d;
      lst_q     <= lst_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = gnt_idx_q;
  assign gnt_vld = gnt_vld_q;

endmodule

// File: doc/arb_rr_oht.md
Name: arb_rr_oht

Overview:
- Registered round-robin arbiter built around the rightmost priority-to-one-hot conversion.
- Masks the request vector with a rotating pointer and resolves it to a one-hot grant using the LSB-first priority rule.
- Holds each grant under a valid/ready handshake.
- Sits upstream of any consumer needing a stable one-hot select, such as a mux, bus port or FIFO write select.

Parameters:
- WIDTH, 8, number of requesters; must be >= 2.
- WIDTH_LOG, $clog2(WIDTH), localparam; width of the binary grant index.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  WIDTH  request vector; bit i = requester i.
- gnt  output  WIDTH  registered one-hot grant; all zeros when gnt_vld=0.
- gnt_idx  output  WIDTH_LOG  binary index of the set gnt bit; 0 when gnt_vld=0.
- gnt_vld  output  1  grant valid.
- gnt_rdy  input  1  consumer accepts grant; transfer = gnt_vld & gnt_rdy.

Interface (already decided): one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - gnt=0, gnt_idx=0, gnt_vld=0.
  - Pointer register lst (one-hot, last served) = bit WIDTH-1, so the first arbitration favours bit 0.
- Reset deassertion is synchronous to clk. Reset mid-grant discards the grant with no transfer.
- State is two-phase, derived from gnt_vld:
  - IDLE (gnt_vld=0).
  - GRANT (gnt_vld=1).
- Load condition: ld = ~gnt_vld | gnt_rdy.
- Pointer source: ptr = transfer ? gnt : lst.
- Mask: msk[i]=1 for all i strictly above the set bit of ptr. When ptr has bit WIDTH-1 set, msk=0.
- Selection:
  - sel = rightmost one-hot of (req & msk) if that is nonzero, otherwise rightmost one-hot of req (wrap-around).
  - Arithmetic form (x & -x) or loop form both allowed; result must be identical.
- On ld:
  - gnt <= sel, gnt_vld <= |req, gnt_idx <= binary encode of sel.
- On transfer: lst <= gnt. lst is otherwise unchanged; it is never updated in IDLE.
- Latency: one cycle from req asserted in IDLE to gnt_vld=1.
- Back-to-back: a transfer and a new grant happen in the same cycle. Sustained throughput is one grant per cycle.
- Backpressure: while gnt_vld=1 and gnt_rdy=0, gnt and gnt_idx are held stable even if req changes or the granted request drops.
- Simultaneous events:
  - Transfer with req=0 -> IDLE next cycle.
  - Transfer where only the just-served bit requests -> same bit re-granted (wrap-around path).
- gnt_rdy is ignored in IDLE.
- Invariants: gnt is always one-hot or zero. gnt_vld == |gnt.

Optional Feature:
- Macro ARB_RR_LOCK_EN.
- When defined:
  - Extra input port lck (1 bit), ordered after gnt_rdy.
  - If transfer & lck & |(req & gnt), sel is forced to gnt and lst is not updated, so the same requester keeps ownership for multi-beat bursts.
  - Otherwise behaviour is as specified above.
- When undefined: no lck port; pure round-robin.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle with gnt_vld=1 -> gnt=0, gnt_idx=0, gnt_vld=0 immediately; after release, req=8'hFF -> gnt=8'h01 one cycle later.
- Rotation: req=8'hFF held, gnt_rdy=1 -> gnt_idx sequence 0,1,2,...,7,0, one grant per cycle.
- Sparse with wrap: req=8'h91, gnt_rdy=1 -> gnt 8'h01, 8'h10, 8'h80, 8'h01.
- Backpressure: req=8'h06, gnt_rdy=0 for 5 cycles -> gnt=8'h02 held stable; req changed to 8'h04 during the hold -> gnt still 8'h02; gnt_rdy=1 -> next cycle gnt=8'h04.
- Single requester: req=8'h20 held, gnt_rdy=1 -> gnt=8'h20 every cycle; req=0 at a transfer -> gnt_vld=0 next cycle.
- Lock (ARB_RR_LOCK_EN): req=8'h03, lck=1 for 3 transfers -> gnt=8'h01 for 3 grants; lck=0 -> gnt=8'h02.
